motor_ramp_sequencer: RTL and testbench

//  Sits between the host command interface and the per-H-bridge motor_controller instances.

---
 rtl/motor_ramp_sequencer_pkg.sv | 21 ++
 rtl/motor_ramp_sequencer_tick_prescaler.sv | 27 ++
 rtl/motor_ramp_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_motor_ramp_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/motor_ramp_sequencer_pkg.sv
// Shared encodings for the motor ramp sequencer: duty width default and per-motor state codes.
`ifndef DUTY_CYCLE_SIZE
`define DUTY_CYCLE_SIZE 10
`endif
`ifndef MOTOR_ST_OFF
`define MOTOR_ST_OFF   2'd0
`define MOTOR_ST_RUN   2'd1
`define MOTOR_ST_DRAIN 2'd2
`define MOTOR_ST_DEAD  2'd3
`endif

package motor_ramp_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = `MOTOR_ST_OFF,
        ST_RUN   = `MOTOR_ST_RUN,
        ST_DRAIN = `MOTOR_ST_DRAIN,
        ST_DEAD  = `MOTOR_ST_DEAD
    } motor_st_e;

endpackage

// File: rtl/motor_ramp_sequencer_tick_prescaler.sv
// Divide-by-DIV event counter; used for the ramp tick and, clocked by ramp ticks, as the watchdog.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Per-motor duty ramp / reversal sequencer with command watchdog and emergency stop.
// state | meaning
// OFF   | bridge disabled, waiting for an enabled target
// RUN   | enabled, duty slewing toward target
// DRAIN | ramping duty down before reversal or shutdown
// DEAD  | fully off for REV_HOLD ticks before re-enable
`ifndef DUTY_CYCLE_SIZE
`define DUTY_CYCLE_SIZE 10
`endif

module motor_ramp_sequencer #(
    parameter int N_MOTORS   = 8,
    parameter int IDX_W      = 3,
    parameter int DC_W       = `DUTY_CYCLE_SIZE,
    parameter int MAX_DUTY   = 900,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 16,
    parameter int REV_HOLD   = 8,
    parameter int WDOG_TICKS = 500
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [IDX_W-1:0]         cmd_motor,
    input  logic                     cmd_dir,
    input  logic                     cmd_on,
    input  logic [DC_W-1:0]          cmd_duty,
    input  logic                     estop,
    output logic [N_MOTORS-1:0]      motor_dir,
    output logic [N_MOTORS-1:0]      motor_on,
    output logic [N_MOTORS*DC_W-1:0] motor_duty,
    output logic                     busy,
    output logic                     wdog_trip
);
    import motor_ramp_sequencer_pkg::*;

    localparam int SIDX_W = (N_MOTORS > 1) ? $clog2(N_MOTORS) : 1;
    localparam int HOLD_W = (REV_HOLD > 1) ? $clog2(REV_HOLD) : 1;
    localparam logic [DC_W:0]   STEP_EXT = (DC_W + 1)'(RAMP_STEP);
    localparam logic [DC_W-1:0] MAX_D    = DC_W'(MAX_DUTY);

    logic              ready_q, accept, ramp_tick, wd_tick, wd_fire, trip_q;
    logic              sweep_active;
    logic [SIDX_W-1:0] sweep_idx;
    logic [DC_W-1:0]   duty_clip;

    logic [N_MOTORS-1:0] tgt_on_q, tgt_dir_q, dir_q, on_q;
    logic [DC_W-1:0]     tgt_duty_q [N_MOTORS];
    logic [DC_W-1:0]     duty_q [N_MOTORS];
    logic [HOLD_W-1:0]   hold_q [N_MOTORS];
    motor_st_e           st_q [N_MOTORS];

    motor_st_e         cur_st, st_nxt;
    logic              cur_dir, cur_on, cur_tgt_on, cur_tgt_dir, rev, drain_zero;
    logic              dir_nxt, on_nxt;
    logic [DC_W-1:0]   cur_duty, cur_tgt_duty, duty_nxt;
    logic [HOLD_W-1:0] cur_hold, hold_nxt;
    logic [DC_W:0]     cur_ext, tgt_ext, up_sum, drain_val, ramp_val, start_val;

    assign cmd_ready = ready_q;
    assign busy      = sweep_active;
    assign wdog_trip = trip_q;
    assign motor_dir = dir_q;
    assign motor_on  = on_q;
    assign accept    = cmd_valid && ready_q;
    assign duty_clip = (cmd_duty > MAX_D) ? MAX_D : cmd_duty;
    assign wd_fire   = wd_tick && !accept;

    always_comb begin
        motor_duty = '0;
        for (int i = 0; i < N_MOTORS; i++) motor_duty[i*DC_W +: DC_W] = duty_q[i];
    end

    tick_prescaler #(.DIV(RAMP_DIV)) u_ramp_div (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .en(1'b1), .tick(ramp_tick)
    );

    generate
        if (WDOG_TICKS > 0) begin : g_wdog
            tick_prescaler #(.DIV(WDOG_TICKS)) u_wdog (
                .clk(clk), .reset_n(reset_n), .clr(accept), .en(ramp_tick), .tick(wd_tick)
            );
        end else begin : g_no_wdog
            assign wd_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            trip_q       <= 1'b0;
            sweep_active <= 1'b0;
            sweep_idx    <= '0;
        end else begin
            ready_q <= !estop;
            if (accept)       trip_q <= 1'b0;
            else if (wd_fire) trip_q <= 1'b1;
            // a tick landing on the final slot must still start the next sweep
            if (estop) begin
                sweep_active <= 1'b0;
                sweep_idx    <= '0;
            end else if (sweep_active && sweep_idx != SIDX_W'(N_MOTORS - 1)) begin
                sweep_idx <= sweep_idx + 1'b1;
            end else if (ramp_tick) begin
                sweep_active <= 1'b1;
                sweep_idx    <= '0;
            end else begin
                sweep_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_on_q  <= '0;
            tgt_dir_q <= '0;
            for (int i = 0; i < N_MOTORS; i++) tgt_duty_q[i] <= '0;
        end else if (estop) begin
            tgt_on_q  <= '0;
            tgt_dir_q <= '0;
            for (int i = 0; i < N_MOTORS; i++) tgt_duty_q[i] <= '0;
        end else begin
            if (wd_fire) tgt_on_q <= '0;
            for (int i = 0; i < N_MOTORS; i++) begin
                if (accept && cmd_motor == IDX_W'(i)) begin
                    tgt_on_q[i]   <= cmd_on;
                    tgt_dir_q[i]  <= cmd_dir;
                    tgt_duty_q[i] <= duty_clip;
                end
            end
        end
    end

    // Shared ramp datapath, muxed by sweep slot
    always_comb begin
        cur_st       = st_q[sweep_idx];
        cur_dir      = dir_q[sweep_idx];
        cur_on       = on_q[sweep_idx];
        cur_duty     = duty_q[sweep_idx];
        cur_hold     = hold_q[sweep_idx];
        cur_tgt_on   = tgt_on_q[sweep_idx];
        cur_tgt_dir  = tgt_dir_q[sweep_idx];
        cur_tgt_duty = tgt_duty_q[sweep_idx];
        cur_ext      = {1'b0, cur_duty};
        tgt_ext      = {1'b0, cur_tgt_duty};
        up_sum       = cur_ext + STEP_EXT;
        drain_val    = (cur_ext > STEP_EXT) ? cur_ext - STEP_EXT : '0;
        drain_zero   = (drain_val == '0);
        start_val    = (tgt_ext < STEP_EXT) ? tgt_ext : STEP_EXT;
        rev          = !cur_tgt_on || (cur_tgt_dir != cur_dir);
        if (cur_ext < tgt_ext)                  ramp_val = (up_sum > tgt_ext) ? tgt_ext : up_sum;
        else if (cur_ext - tgt_ext > STEP_EXT)  ramp_val = cur_ext - STEP_EXT;
        else                                    ramp_val = tgt_ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q <= '0;
            on_q  <= '0;
            for (int i = 0; i < N_MOTORS; i++) begin
                st_q[i]   <= ST_OFF;
                duty_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else if (estop) begin
            on_q <= '0;
            for (int i = 0; i < N_MOTORS; i++) begin
                st_q[i]   <= ST_OFF;
                duty_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else if (sweep_active) begin
            st_q[sweep_idx]   <= st_nxt;
            hold_q[sweep_idx] <= hold_nxt;
            dir_q[sweep_idx]  <= dir_nxt;
            on_q[sweep_idx]   <= on_nxt;
            duty_q[sweep_idx] <= duty_nxt;
        end
    end

    always_comb begin
        st_nxt   = cur_st;
        hold_nxt = cur_hold;
        case (cur_st)
            ST_OFF:   if (cur_tgt_on) st_nxt = ST_RUN;
            ST_RUN:   if (rev) st_nxt = drain_zero ? ST_DEAD : ST_DRAIN;
            ST_DRAIN: if (drain_zero) st_nxt = ST_DEAD;
            ST_DEAD: begin
                if (cur_hold == HOLD_W'(REV_HOLD - 1)) st_nxt = ST_OFF;
                else hold_nxt = cur_hold + 1'b1;
            end
            default:  st_nxt = ST_OFF;
        endcase
        if (st_nxt == ST_DEAD && cur_st != ST_DEAD) hold_nxt = '0;
    end

    always_comb begin
        dir_nxt  = cur_dir;
        on_nxt   = cur_on;
        duty_nxt = cur_duty;
        case (cur_st)
            ST_OFF: begin
                if (cur_tgt_on) begin
                    dir_nxt  = cur_tgt_dir;
                    on_nxt   = 1'b1;
                    duty_nxt = start_val[DC_W-1:0];
                end else begin
                    on_nxt   = 1'b0;
                    duty_nxt = '0;
                end
            end
            ST_RUN: begin
                if (rev) begin
                    on_nxt   = !drain_zero;
                    duty_nxt = drain_val[DC_W-1:0];
                end else begin
                    duty_nxt = ramp_val[DC_W-1:0];
                end
            end
            ST_DRAIN: begin
                on_nxt   = !drain_zero;
                duty_nxt = drain_val[DC_W-1:0];
            end
            default: begin
                on_nxt   = 1'b0;
                duty_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: ramp, reversal, clamp, watchdog, estop, slot collision.
module tb_motor_ramp_sequencer;
    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_on = 1'b0, estop = 1'b0;
    logic [IW-1:0] cmd_motor = '0;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_ready, busy, wdog_trip;
    logic [N-1:0]  motor_dir, motor_on;
    logic [N*DW-1:0] motor_duty;

    int n_checks = 0;
    int n_errors = 0;

    localparam int REV_DUTY [8] = '{250, 150, 50, 0, 0, 0, 100, 200};
    localparam int REV_ON   [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    localparam int REV_DIR  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

    always #5 clk = ~clk;

    motor_ramp_sequencer #(
        .N_MOTORS(N), .IDX_W(IW), .DC_W(DW), .MAX_DUTY(900), .RAMP_DIV(8),
        .RAMP_STEP(100), .REV_HOLD(2), .WDOG_TICKS(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_motor(cmd_motor), .cmd_dir(cmd_dir), .cmd_on(cmd_on), .cmd_duty(cmd_duty),
        .estop(estop), .motor_dir(motor_dir), .motor_on(motor_on), .motor_duty(motor_duty),
        .busy(busy), .wdog_trip(wdog_trip)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int duty_of(input int m);
        return int'(motor_duty[m*DW +: DW]);
    endfunction

    task automatic wait_busy_rise();
        int k = 0;
        while (!busy && k < 40) begin @(negedge clk); k++; end
        if (!busy) check_val("busy_rise_timeout", int'(busy), 1);
    endtask

    task automatic wait_busy_fall();
        int k = 0;
        while (busy && k < 40) begin @(negedge clk); k++; end
        if (busy) check_val("busy_fall_timeout", int'(busy), 0);
    endtask

    task automatic wait_sweep();
        wait_busy_rise();
        wait_busy_fall();
    endtask

    task automatic send_cmd(input int m, input bit d, input bit o, input int duty);
        cmd_motor = IW'(m);
        cmd_dir   = d;
        cmd_on    = o;
        cmd_duty  = DW'(duty);
        cmd_valid = 1'b1;
        check_val("cmd_ready_at_accept", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int hi, lo;
        // 1: reset state and sweep cadence
        repeat (3) @(negedge clk);
        check_val("rst_ready", int'(cmd_ready), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_on", int'(motor_on), 0);
        check_val("rst_dir", int'(motor_dir), 0);
        check_val("rst_duty_nz", int'(motor_duty != '0), 0);
        check_val("rst_trip", int'(wdog_trip), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_release", int'(cmd_ready), 1);
        wait_busy_rise();
        hi = 1;
        for (int k = 0; k < 20 && busy; k++) begin @(negedge clk); if (busy) hi++; end
        check_val("busy_high_cycles", hi, 4);
        lo = 1;
        for (int k = 0; k < 20 && !busy; k++) begin @(negedge clk); if (!busy) lo++; end
        check_val("busy_low_cycles", lo, 4);
        wait_busy_fall();

        // 2: ramp up motor1 to 350
        send_cmd(1, 0, 1, 350);
        for (int t = 0; t < 5; t++) begin
            wait_sweep();
            check_val("up_duty", duty_of(1), (t < 3) ? 100 * (t + 1) : 350);
            check_val("up_on_mask", int'(motor_on), 2);
            check_val("up_dir", int'(motor_dir[1]), 0);
        end
        check_val("up_other_duty", duty_of(0) + duty_of(2) + duty_of(3), 0);

        // 3: reversal through drain and dead time
        send_cmd(1, 1, 1, 200);
        for (int t = 0; t < 8; t++) begin
            wait_sweep();
            check_val("rev_duty", duty_of(1), REV_DUTY[t]);
            check_val("rev_on", int'(motor_on[1]), REV_ON[t]);
            check_val("rev_dir", int'(motor_dir[1]), REV_DIR[t]);
        end

        // 4: duty clamp and out-of-range motor index
        send_cmd(1, 1, 1, 1023);
        for (int t = 0; t < 8; t++) begin
            wait_sweep();
            check_val("clamp_duty", duty_of(1), (t < 7) ? 300 + 100 * t : 900);
        end
        send_cmd(5, 0, 1, 500);
        wait_sweep();
        check_val("idx5_on_mask", int'(motor_on), 2);
        check_val("idx5_duty1", duty_of(1), 900);

        // 5: watchdog trip and drain, cleared by next command
        for (int t = 2; t <= 9; t++) wait_sweep();
        check_val("wdog_not_yet", int'(wdog_trip), 0);
        check_val("wdog_hold_duty", duty_of(1), 900);
        for (int t = 10; t <= 18; t++) begin
            wait_sweep();
            check_val("wdog_drain_duty", duty_of(1), 900 - 100 * (t - 9));
            check_val("wdog_drain_on", int'(motor_on[1]), (t < 18) ? 1 : 0);
        end
        check_val("wdog_trip_set", int'(wdog_trip), 1);
        send_cmd(2, 0, 1, 500);
        check_val("wdog_trip_clear", int'(wdog_trip), 0);
        for (int t = 1; t <= 3; t++) begin
            wait_sweep();
            check_val("resume_duty", duty_of(2), 100 * t);
        end
        check_val("resume_m1_off", duty_of(1), 0);

        // 6: estop mid-ramp, then slot collision
        wait_busy_rise();
        estop = 1'b1;
        @(negedge clk);
        check_val("estop_on", int'(motor_on), 0);
        check_val("estop_duty_nz", int'(motor_duty != '0), 0);
        check_val("estop_ready", int'(cmd_ready), 0);
        check_val("estop_busy", int'(busy), 0);
        hi = 0;
        for (int k = 0; k < 16; k++) begin @(negedge clk); if (busy) hi++; end
        check_val("estop_no_sweep", hi, 0);
        estop = 1'b0;
        @(negedge clk);
        check_val("release_ready", int'(cmd_ready), 1);
        wait_sweep();
        wait_sweep();
        check_val("release_on", int'(motor_on), 0);
        check_val("release_duty_nz", int'(motor_duty != '0), 0);
        wait_busy_rise();
        send_cmd(0, 0, 1, 200);
        wait_busy_fall();
        check_val("collide_same_tick_on", int'(motor_on[0]), 0);
        check_val("collide_same_tick_duty", duty_of(0), 0);
        wait_sweep();
        check_val("collide_next_on", int'(motor_on[0]), 1);
        check_val("collide_next_duty", duty_of(0), 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
